// File: rtl/arb8_grant_ctrl_if.sv
// Request/grant bundle between the 8 clients and the arbiter.
// master = client side (drives req), slave = arbiter side (drives grant status).
interface arb8_grant_ctrl_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [3:0] gnt_code;
  logic       busy;
  logic       timeout;

  modport master (output req, input gnt, gnt_code, busy, timeout);
  modport slave  (input req, output gnt, gnt_code, busy, timeout);
endinterface

// File: rtl/arb8_grant_ctrl.sv
// 8-requester grant controller: registered one-hot grant, held until owner drop or hold timeout.
// ROUND_ROBIN_EN selects rotating priority; default build is fixed priority (req[7] highest).
module arb8_grant_ctrl #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  arb8_grant_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       gnt;
  logic [3:0]       gnt_code;
  logic             busy;
  logic             timeout;
  logic [2:0]       win;
  logic [2:0]       owner;

  assign owner = gnt_code[2:0];

`ifdef ROUND_ROBIN_EN
  logic [2:0] rr_ptr;

  // Scan downward from rr_ptr (inclusive) with wrap; rr_ptr trails the last owner.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    win   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = rr_ptr - 3'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Highest asserted index wins; later loop iterations override earlier ones.
  always_comb begin
    win = 3'd0;
    for (int i = 0; i < 8; i++)
      if (bus.req[i]) win = 3'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_code <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_ptr   <= 3'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= GRANT;
            gnt      <= 8'b1 << win;
            gnt_code <= {1'b1, win};
            busy     <= 1'b1;
            hold_cnt <= CNT_W'(1);
          end
        end
        GRANT: begin
          // Owner drop takes precedence, so a coincident timeout is a normal release.
          if (!bus.req[owner] || hold_cnt == CNT_W'(HOLD_MAX)) begin
            state    <= RELEASE;
            gnt      <= '0;
            gnt_code <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            timeout  <= bus.req[owner];
`ifdef ROUND_ROBIN_EN
            rr_ptr   <= owner - 3'd1;
`endif
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt;
  assign bus.gnt_code = gnt_code;
  assign bus.busy     = busy;
  assign bus.timeout  = timeout;

endmodule

// File: tb/tb_arb8_grant_ctrl.sv
// Directed bench for arb8_grant_ctrl: reset, priority, timeout, no-preemption,
// coincident drop/timeout, back-to-back ordering and async reset mid-grant.
module tb_arb8_grant_ctrl;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;

  arb8_grant_ctrl_if bus();

  arb8_grant_ctrl #(.HOLD_MAX(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.req = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [7:0] exp_gnt;
    logic [3:0] exp_code;
`ifdef ROUND_ROBIN_EN
    exp_gnt = 8'h01; exp_code = 4'b1000;
`else
    exp_gnt = 8'h80; exp_code = 4'b1111;
`endif
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    repeat (2) tick();
    chk_cnt++; if (bus.gnt !== 8'h00) $display("FAIL reset_gnt: got %h expected %h", bus.gnt, 8'h00); else pass_cnt++;
    chk_cnt++; if (bus.gnt_code !== 4'h0) $display("FAIL reset_code: got %h expected %h", bus.gnt_code, 4'h0); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", bus.timeout); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_cnt++; if (bus.gnt !== exp_gnt) $display("FAIL first_gnt: got %h expected %h", bus.gnt, exp_gnt); else pass_cnt++;
    chk_cnt++; if (bus.gnt_code !== exp_code) $display("FAIL first_code: got %b expected %b", bus.gnt_code, exp_code); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL first_busy: got %b expected 1", bus.busy); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_priority();
    bus.req = 8'b0100_1000;
    tick();
    chk_cnt++; if (bus.gnt !== 8'h40) $display("FAIL prio_gnt: got %h expected %h", bus.gnt, 8'h40); else pass_cnt++;
    chk_cnt++; if (bus.gnt_code !== 4'b1110) $display("FAIL prio_code: got %b expected 1110", bus.gnt_code); else pass_cnt++;
    bus.req = 8'b0000_1000;
    tick();
    chk_cnt++; if (bus.gnt !== 8'h00) $display("FAIL prio_release: got %h expected %h", bus.gnt, 8'h00); else pass_cnt++;
    repeat (2) tick();
    chk_cnt++; if (bus.gnt !== 8'h08) $display("FAIL prio_next_gnt: got %h expected %h", bus.gnt, 8'h08); else pass_cnt++;
    chk_cnt++; if (bus.gnt_code !== 4'b1011) $display("FAIL prio_next_code: got %b expected 1011", bus.gnt_code); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_timeout();
    int n;
    bus.req = 8'h01;
    tick();
    n = 0;
    while (bus.gnt === 8'h01 && bus.timeout === 1'b0 && n < 40) begin
      n++;
      tick();
    end
    chk_cnt++; if (n != 16) $display("FAIL hold_cycles: got %0d expected 16", n); else pass_cnt++;
    chk_cnt++; if (bus.timeout !== 1'b1) $display("FAIL timeout_pulse: got %b expected 1", bus.timeout); else pass_cnt++;
    chk_cnt++; if (bus.gnt !== 8'h00) $display("FAIL timeout_gnt: got %h expected %h", bus.gnt, 8'h00); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.timeout !== 1'b0) $display("FAIL timeout_width: got %b expected 0", bus.timeout); else pass_cnt++;
    chk_cnt++; if (bus.gnt !== 8'h00) $display("FAIL dead_cycle: got %h expected %h", bus.gnt, 8'h00); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.gnt !== 8'h01) $display("FAIL regrant: got %h expected %h", bus.gnt, 8'h01); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_no_preempt();
    bit held;
    bus.req = 8'h02;
    tick();
    chk_cnt++; if (bus.gnt !== 8'h02) $display("FAIL np_gnt: got %h expected %h", bus.gnt, 8'h02); else pass_cnt++;
    bus.req = 8'h82;
    held = 1'b1;
    repeat (4) begin
      tick();
      if (bus.gnt !== 8'h02) held = 1'b0;
    end
    chk_cnt++; if (held !== 1'b1) $display("FAIL np_hold: got %h expected %h", bus.gnt, 8'h02); else pass_cnt++;
    bus.req = 8'h80;
    repeat (3) tick();
    chk_cnt++; if (bus.gnt !== 8'h80) $display("FAIL np_after: got %h expected %h", bus.gnt, 8'h80); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_drop_at_limit();
    bus.req = 8'h01;
    repeat (16) tick();
    chk_cnt++; if (bus.gnt !== 8'h01) $display("FAIL limit_gnt: got %h expected %h", bus.gnt, 8'h01); else pass_cnt++;
    bus.req = 8'h00;
    tick();
    chk_cnt++; if (bus.timeout !== 1'b0) $display("FAIL limit_no_timeout: got %b expected 0", bus.timeout); else pass_cnt++;
    chk_cnt++; if (bus.gnt !== 8'h00) $display("FAIL limit_release: got %h expected %h", bus.gnt, 8'h00); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_idx [9];
    int n;
`ifdef ROUND_ROBIN_EN
    exp_idx = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
`else
    exp_idx = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
    rst_n = 1'b0;
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      n = 0;
      while (bus.gnt === 8'h00 && n < 10) begin
        tick();
        n++;
      end
      chk_cnt++;
      if (bus.gnt_code !== {1'b1, exp_idx[k]})
        $display("FAIL b2b_grant_%0d: got %b expected %b", k, bus.gnt_code, {1'b1, exp_idx[k]});
      else pass_cnt++;
      tick();
      bus.req = 8'hFF & ~bus.gnt;
      tick();
      bus.req = 8'hFF;
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    bus.req = 8'h01;
    repeat (2) tick();
    chk_cnt++; if (bus.gnt !== 8'h01) $display("FAIL ar_pre: got %h expected %h", bus.gnt, 8'h01); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus.gnt !== 8'h00) $display("FAIL ar_gnt: got %h expected %h", bus.gnt, 8'h00); else pass_cnt++;
    chk_cnt++; if (bus.timeout !== 1'b0) $display("FAIL ar_timeout: got %b expected 0", bus.timeout); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL ar_busy: got %b expected 0", bus.busy); else pass_cnt++;
    #1 rst_n = 1'b1;
    tick();
    chk_cnt++; if (bus.gnt !== 8'h01) $display("FAIL ar_restart: got %h expected %h", bus.gnt, 8'h01); else pass_cnt++;
    go_idle();
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    test_reset();
    test_priority();
    test_timeout();
    test_no_preempt();
    test_drop_at_limit();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
